// File: rtl/debug_pkg.sv
// Shared constants for the debug step controller: command bytes, report header,
// status bit positions and the controller state encoding.
package debug_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_RST  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_PEEK = 8'h70;  // 'p'

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  localparam int ST_HALT = 0;
  localparam int ST_HOST = 1;
  localparam int ST_TMO  = 2;

  localparam logic [2:0] ENC_IDLE = 3'd0;
  localparam logic [2:0] ENC_RUN  = 3'd1;
  localparam logic [2:0] ENC_STEP = 3'd2;
  localparam logic [2:0] ENC_RST  = 3'd3;
  localparam logic [2:0] ENC_SEND = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ENC_IDLE,
    S_RUN  = ENC_RUN,
    S_STEP = ENC_STEP,
    S_RST  = ENC_RST,
    S_SEND = ENC_SEND
  } dbg_state_e;

endpackage

// File: rtl/debug_report_serializer.sv
// Parallel-load byte serializer for the status report. The first byte is
// presented straight from the top of the shift register, so tx_data is a flop.
module debug_report_serializer #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       hdr,
  input  logic [7:0]       status,
  input  logic [7:0]       pc,
  input  logic [CYC_W-1:0] cycles,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             done
);

  localparam int NB = 3 + CYC_W / 8;
  localparam int SW = 8 * NB;

  logic [SW-1:0] shreg_q;
  logic [3:0]    left_q;  // bytes still queued behind the one on tx_data

  assign tx_data = shreg_q[SW-1 -: 8];
  assign done    = tx_valid && tx_ready && (left_q == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q  <= '0;
      left_q   <= '0;
      tx_valid <= 1'b0;
    end else if (start) begin
      shreg_q  <= {hdr, status, pc, cycles};
      left_q   <= 4'(NB - 1);
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      shreg_q <= {shreg_q[SW-9:0], 8'h00};
      if (left_q == 4'd0) tx_valid <= 1'b0;
      else                left_q   <= left_q - 4'd1;
    end
  end

endmodule

// File: rtl/debug_step_controller.sv
// Host-side debug stepping controller: decodes UART command bytes, drives the
// pipeline enable/reset, and returns a status/PC/cycle report after each command.
module debug_step_controller
  import debug_pkg::*;
#(
  parameter int               PC_W      = 8,
  parameter int               CYC_W     = 16,
  parameter logic [CYC_W-1:0] RUN_LIMIT = CYC_W'(16'hFFFF),
  parameter logic [7:0]       HDR       = HDR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic [PC_W-1:0] pc_value,
  input  logic            halt_seen,
  output logic            enable_debug,
  output logic            reset_debug
);

  // Handshakes: a byte moves on a rising edge where valid && ready are both high;
  // the sender holds data stable while valid is high and ready is low.

  dbg_state_e       state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, run_q, run_d, cyc_snap_q;
  logic [PC_W-1:0]  pc_snap_q;
  logic [2:0]       status_q, status_d;
  logic             start_q, rx_fire, enter_send, ser_done;

  assign rx_fire    = rx_valid && rx_ready;
  assign enter_send = (state_d == S_SEND) && (state_q != S_SEND);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    run_d    = run_q;
    cyc_d    = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          status_d = '0;
          case (rx_data)
            CMD_RUN: begin
              run_d = '0;
              if (halt_seen) begin
                status_d[ST_HALT] = 1'b1;
                state_d           = S_SEND;
              end else begin
                state_d = S_RUN;
              end
            end
            CMD_STEP: state_d = S_STEP;
            CMD_RST:  state_d = S_RST;
            CMD_PEEK: state_d = S_SEND;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_STEP: begin
        cyc_d   = cyc_q + 1'b1;
        state_d = S_SEND;
      end
      S_RUN: begin
        // Every RUN cycle was enabled, including the one on which we stop.
        cyc_d   = cyc_q + 1'b1;
        run_d   = run_q + 1'b1;
        state_d = S_SEND;
        if (halt_seen)                       status_d[ST_HALT] = 1'b1;
        else if (rx_fire)                    status_d[ST_HOST] = 1'b1;
        else if (run_q == RUN_LIMIT - 1'b1)  status_d[ST_TMO]  = 1'b1;
        else                                 state_d           = S_RUN;
      end
      S_RST: begin
        cyc_d    = '0;
        status_d = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (ser_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      status_q     <= '0;
      cyc_q        <= '0;
      run_q        <= '0;
      cyc_snap_q   <= '0;
      pc_snap_q    <= '0;
      start_q      <= 1'b0;
      enable_debug <= 1'b0;
      reset_debug  <= 1'b0;
      rx_ready     <= 1'b1;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      cyc_q        <= cyc_d;
      run_q        <= run_d;
      start_q      <= enter_send;
      enable_debug <= (state_d == S_RUN) || (state_d == S_STEP);
      reset_debug  <= (state_d == S_RST);
      rx_ready     <= (state_d == S_IDLE) || (state_d == S_RUN);
      if (enter_send) begin
        pc_snap_q  <= pc_value;
        cyc_snap_q <= cyc_d;
      end
    end
  end

  debug_report_serializer #(.CYC_W(CYC_W)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .start    (start_q),
    .hdr      (HDR),
    .status   ({5'b0, status_q}),
    .pc       (8'(pc_snap_q)),
    .cycles   (cyc_snap_q),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (ser_done)
  );

endmodule
